time_keeper: RTL and testbench

- Timekeeping and alarm register bank. It is the responder to the mode FSM, which issues field-select and adjust commands from debounced button pulses.
- Holds current time (HH:MM:SS, 24 h) and alarm time (HH:MM). Advances time once per second while enabled, applies inc/dec adjustments, and raises the alarm on match.
- Feeds BCD digits and a blink strobe to the display path.

---
 rtl/time_keeper.sv | 143 ++++++++++++++
 tb/tb_time_keeper.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// Timekeeping and alarm register bank: seconds prescaler, HH:MM:SS time, HH:MM alarm,
// manual inc/dec adjust, alarm ring with timeout, and BCD/blink outputs for the display path.
module time_keeper #(
    parameter int TICK_DIV   = 100000000,
    parameter int ALARM_SECS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [1:0]  sel,
    input  logic        inc,
    input  logic        dec,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    output logic [15:0] time_bcd,
    output logic [15:0] alarm_bcd,
    output logic [5:0]  sec_bin,
    output logic        sec_tick,
    output logic        blink,
    output logic        alarm_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF  = PW'(TICK_DIV / 2);
    localparam logic [RW-1:0] RING_LAST = RW'(ALARM_SECS - 1);

    logic [PW-1:0] pre;
    logic [4:0]    hours, alarm_hours, hours_nx;
    logic [5:0]    minutes, alarm_minutes, minutes_nx;
    logic [5:0]    seconds, seconds_nx;
    logic [RW-1:0] ring;
    logic          adj, time_adj, advance, set_alarm, ring_done;

    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
        if (up) return (h == 5'd23) ? 5'd0 : h + 5'd1;
        else    return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] minute_step(input logic [5:0] m, input logic up);
        if (up) return (m == 6'd59) ? 6'd0 : m + 6'd1;
        else    return (m == 6'd0) ? 6'd59 : m - 6'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        if (v >= 6'd50) begin
            tens  = 4'd5;
            units = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            tens  = 4'd4;
            units = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            tens  = 4'd3;
            units = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            tens  = 4'd2;
            units = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            tens  = 4'd1;
            units = 4'(v - 6'd10);
        end else begin
            tens  = 4'd0;
            units = v[3:0];
        end
        return {tens, units};
    endfunction

    assign sec_tick  = (pre == PRE_LAST);
    assign blink     = (pre >= PRE_HALF);
    assign sec_bin   = seconds;
    assign time_bcd  = {to_bcd({1'b0, hours}), to_bcd(minutes)};
    assign alarm_bcd = {to_bcd({1'b0, alarm_hours}), to_bcd(alarm_minutes)};

    // A manual time-field adjust on a tick edge swallows that tick completely.
    always_comb begin
        adj        = inc ^ dec;
        time_adj   = adj & ~sel[1];
        advance    = sec_tick & run & ~time_adj;
        seconds_nx = seconds;
        minutes_nx = minutes;
        hours_nx   = hours;
        if (advance) begin
            if (seconds == 6'd59) begin
                seconds_nx = 6'd0;
                if (minutes == 6'd59) begin
                    minutes_nx = 6'd0;
                    hours_nx   = hour_step(hours, 1'b1);
                end else begin
                    minutes_nx = minutes + 6'd1;
                end
            end else begin
                seconds_nx = seconds + 6'd1;
            end
        end else if (time_adj) begin
            if (sel[0]) begin
                minutes_nx = minute_step(minutes, inc);
                seconds_nx = 6'd0;
            end else begin
                hours_nx = hour_step(hours, inc);
            end
        end
        set_alarm = alarm_en & advance & (seconds_nx == 6'd0) &
                    (minutes_nx == alarm_minutes) & (hours_nx == alarm_hours);
        ring_done = alarm_active & sec_tick & (ring == RING_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre           <= '0;
            hours         <= '0;
            minutes       <= '0;
            seconds       <= '0;
            alarm_hours   <= '0;
            alarm_minutes <= '0;
        end else begin
            pre     <= sec_tick ? '0 : pre + PW'(1);
            hours   <= hours_nx;
            minutes <= minutes_nx;
            seconds <= seconds_nx;
            if (adj && sel == 2'd2) alarm_hours <= hour_step(alarm_hours, inc);
            if (adj && sel == 2'd3) alarm_minutes <= minute_step(alarm_minutes, inc);
        end
    end

    // A fresh match outranks every clear source on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_active <= 1'b0;
            ring         <= '0;
        end else if (set_alarm) begin
            alarm_active <= 1'b1;
            ring         <= '0;
        end else if (!alarm_en || alarm_ack || ring_done) begin
            alarm_active <= 1'b0;
        end else if (alarm_active && sec_tick) begin
            ring <= ring + RW'(1);
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed steps plus random traffic, checked every cycle against
// a seconds-of-day arithmetic model of the clock, alarm and prescaler.
module tb_time_keeper;

    localparam int TD = 4;
    localparam int AS = 3;

    logic        clk = 1'b0;
    logic        rst, run, inc, dec, alarm_en, alarm_ack;
    logic [1:0]  sel;
    logic [15:0] time_bcd, alarm_bcd;
    logic [5:0]  sec_bin;
    logic        sec_tick, blink, alarm_active;

    int nvec = 0;
    int nerr = 0;

    int m_pre, m_tod, m_ah, m_am, m_rings;
    bit m_act;

    time_keeper #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
        .clk(clk), .rst(rst), .run(run), .sel(sel), .inc(inc), .dec(dec),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack), .time_bcd(time_bcd),
        .alarm_bcd(alarm_bcd), .sec_bin(sec_bin), .sec_tick(sec_tick),
        .blink(blink), .alarm_active(alarm_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd4(input int h, input int m);
        return ((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10);
    endfunction

    function automatic int cur_min();
        return (m_tod / 60) % 60;
    endfunction

    task automatic model_reset();
        m_pre = 0; m_tod = 0; m_ah = 0; m_am = 0; m_act = 0; m_rings = 0;
    endtask

    task automatic model_edge();
        bit tick, adj, tadj, adv, set;
        int h, mi, s, nt;
        if (!rst) begin
            model_reset();
            return;
        end
        tick = (m_pre == TD - 1);
        adj  = inc ^ dec;
        tadj = adj && (sel < 2);
        adv  = tick && run && !tadj;
        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        s  = m_tod % 60;
        nt = m_tod;
        if (adv) nt = (m_tod + 1) % 86400;
        else if (tadj) begin
            if (sel == 0) h = (h + (inc ? 1 : 23)) % 24;
            else begin
                mi = (mi + (inc ? 1 : 59)) % 60;
                s  = 0;
            end
            nt = h * 3600 + mi * 60 + s;
        end
        set = alarm_en && adv && (nt % 60 == 0) && (nt / 60 == m_ah * 60 + m_am);
        if (adj && sel == 2) m_ah = (m_ah + (inc ? 1 : 23)) % 24;
        if (adj && sel == 3) m_am = (m_am + (inc ? 1 : 59)) % 60;
        if (set) begin
            m_act = 1; m_rings = 0;
        end else if (m_act) begin
            if (!alarm_en || alarm_ack) m_act = 0;
            else if (tick) begin
                m_rings++;
                if (m_rings == AS) m_act = 0;
            end
        end
        m_tod = nt;
        m_pre = (m_pre + 1) % TD;
    endtask

    task automatic check_all();
        chk("time_bcd", 32'(time_bcd), bcd4(m_tod / 3600, cur_min()));
        chk("alarm_bcd", 32'(alarm_bcd), bcd4(m_ah, m_am));
        chk("sec_bin", 32'(sec_bin), m_tod % 60);
        chk("sec_tick", 32'(sec_tick), 32'(m_pre == TD - 1));
        chk("blink", 32'(blink), 32'(m_pre >= TD / 2));
        chk("alarm_active", 32'(alarm_active), 32'(m_act));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse(input logic [1:0] s, input logic i, input logic d);
        sel = s; inc = i; dec = d;
        step();
        inc = 1'b0; dec = 1'b0;
    endtask

    initial begin
        int s0;
        rst = 1'b0; run = 1'b0; sel = 2'd0; inc = 1'b0; dec = 1'b0;
        alarm_en = 1'b0; alarm_ack = 1'b0;
        model_reset();
        #2;
        check_all();
        chk("reset_time", 32'(time_bcd), 32'h0000);

        // pulses while held in reset must be ignored
        sel = 2'd0; inc = 1'b1;
        step(); step();
        inc = 1'b0;
        rst = 1'b1;

        // free run: 240 cycles give 60 ticks
        run = 1'b1;
        repeat (240) step();
        chk("after_60_ticks_time", 32'(time_bcd), 32'h0001);
        chk("after_60_ticks_sec", 32'(sec_bin), 32'd0);

        // preload 23:59:58 and roll over
        run = 1'b0;
        pulse(2'd0, 1'b0, 1'b1);
        pulse(2'd1, 1'b0, 1'b1);
        pulse(2'd1, 1'b0, 1'b1);
        chk("preload_2359", 32'(time_bcd), 32'h2359);
        run = 1'b1;
        for (int k = 0; k < 400 && (m_tod % 60) != 58; k++) step();
        for (int k = 0; k < 20 && m_tod != 0; k++) step();
        chk("rollover_time", 32'(time_bcd), 32'h0000);
        chk("rollover_sec", 32'(sec_bin), 32'd0);

        // manual adjust wrap rules
        repeat (12) step();
        run = 1'b0;
        pulse(2'd1, 1'b0, 1'b1);
        chk("min_dec_wrap", 32'(time_bcd), 32'h0059);
        chk("min_adj_clears_sec", 32'(sec_bin), 32'd0);
        pulse(2'd1, 1'b1, 1'b0);
        chk("min_inc_wrap_no_carry", 32'(time_bcd), 32'h0000);
        pulse(2'd1, 1'b1, 1'b1);
        chk("inc_dec_both", 32'(time_bcd), 32'h0000);
        run = 1'b1;
        repeat (8) step();
        run = 1'b0;
        s0 = m_tod % 60;
        pulse(2'd0, 1'b0, 1'b1);
        chk("hour_dec_wrap", 32'(time_bcd), 32'h2300);
        chk("hour_adj_keeps_sec", 32'(sec_bin), s0);

        // alarm 07:30 against time 07:29
        repeat (8) pulse(2'd0, 1'b1, 1'b0);
        repeat (31) pulse(2'd1, 1'b0, 1'b1);
        repeat (7) pulse(2'd2, 1'b1, 1'b0);
        repeat (30) pulse(2'd3, 1'b0, 1'b1);
        chk("alarm_set_0730", 32'(alarm_bcd), 32'h0730);
        alarm_en = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 400 && !m_act; k++) step();
        chk("alarm_rises", 32'(alarm_active), 32'd1);
        chk("alarm_rise_time", 32'(time_bcd), 32'h0730);
        repeat (8) step();
        chk("alarm_still_ringing", 32'(alarm_active), 32'd1);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("alarm_ack_clears", 32'(alarm_active), 32'd0);

        // self-clear after AS ticks
        pulse(2'd3, 1'b1, 1'b0);
        for (int k = 0; k < 400 && !m_act; k++) step();
        chk("alarm_0731_rises", 32'(alarm_active), 32'd1);
        repeat (4 * AS - 1) step();
        chk("alarm_before_timeout", 32'(alarm_active), 32'd1);
        step();
        chk("alarm_timeout", 32'(alarm_active), 32'd0);

        // set and ack on the same edge
        pulse(2'd3, 1'b1, 1'b0);
        alarm_ack = 1'b1;
        for (int k = 0; k < 400 && !m_act; k++) step();
        chk("set_beats_ack", 32'(alarm_active), 32'd1);
        step();
        chk("ack_after_set", 32'(alarm_active), 32'd0);
        alarm_ack = 1'b0;

        // disarm clears
        pulse(2'd3, 1'b1, 1'b0);
        for (int k = 0; k < 400 && !m_act; k++) step();
        chk("alarm_0733_rises", 32'(alarm_active), 32'd1);
        alarm_en = 1'b0;
        step();
        chk("disarm_clears", 32'(alarm_active), 32'd0);

        // adjust colliding with a tick
        run = 1'b0;
        repeat (3) pulse(2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 70 && cur_min() != 15; k++) pulse(2'd1, 1'b1, 1'b0);
        run = 1'b1;
        for (int k = 0; k < 400 && !((m_tod % 60) == 20 && m_pre == TD - 1); k++) step();
        chk("pre_collision_time", 32'(time_bcd), 32'h1015);
        pulse(2'd1, 1'b1, 1'b0);
        chk("collision_time", 32'(time_bcd), 32'h1016);
        chk("collision_sec", 32'(sec_bin), 32'd0);
        for (int k = 0; k < 8 && m_pre != TD - 1; k++) step();
        pulse(2'd3, 1'b1, 1'b0);
        chk("alarm_adj_on_tick_alarm", 32'(alarm_bcd), 32'h0734);
        chk("alarm_adj_on_tick_sec", 32'(sec_bin), 32'd1);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            run       = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            inc       = ($urandom_range(0, 7) == 0);
            dec       = ($urandom_range(0, 7) == 0);
            alarm_en  = ($urandom_range(0, 15) != 0);
            alarm_ack = ($urandom_range(0, 31) == 0);
            step();
        end
        inc = 1'b0; dec = 1'b0; alarm_ack = 1'b0;

        // ring the alarm, then async reset mid-cycle
        run = 1'b0; alarm_en = 1'b1;
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        for (int k = 0; k < 70 && cur_min() != 10; k++) pulse(2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 30 && m_ah != m_tod / 3600; k++) pulse(2'd2, 1'b1, 1'b0);
        for (int k = 0; k < 70 && m_am != 11; k++) pulse(2'd3, 1'b1, 1'b0);
        run = 1'b1;
        for (int k = 0; k < 400 && !m_act; k++) step();
        step(); step();
        chk("ringing_before_reset", 32'(alarm_active), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_reset_alarm", 32'(alarm_active), 32'd0);
        chk("async_reset_time", 32'(time_bcd), 32'h0000);
        chk("async_reset_alarm_bcd", 32'(alarm_bcd), 32'h0000);
        step(); step();
        rst = 1'b1;
        repeat (TD - 2) step();
        chk("no_early_tick", 32'(sec_tick), 32'd0);
        step();
        chk("first_tick_after_reset", 32'(sec_tick), 32'd1);
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
